cacheline_adaptor: RTL

//   Converts single-transfer cacheline requests from the level-two cache into

---
 rtl/cacheline_adaptor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: sits between the L2 cache and physical memory.
// A single-transfer line request from L2 becomes a fixed-length burst of
// BEATS beats on the memory bus. Reads gather the beats into one line, and
// writes split a latched line into beats.
module cacheline_adaptor #(
  parameter  int BEATS      = 4,
  parameter  int BEAT_WIDTH = 64,
  parameter  int ADDR_WIDTH = 32,
  localparam int LINE_WIDTH = BEATS * BEAT_WIDTH,
  localparam int OFFS       = $clog2(LINE_WIDTH / 8),
  localparam int CNT_W      = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  // line side (L2)
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  // burst side (physical memory)
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic                    line_resp_q;
  logic [LINE_WIDTH-1:0]   line_rdata_q;
  logic [LINE_WIDTH-1:0]   rbuf_q;
  logic [LINE_WIDTH-1:0]   rbuf_d;
  logic [LINE_WIDTH-1:0]   wbuf_q;
  logic [ADDR_WIDTH-1:0]   addr_aligned;
  logic                    last_beat;

  // The byte offset within a line never reaches the memory bus.
  logic unused_offset_bits;
  assign unused_offset_bits = ^line_addr[OFFS-1:0];

  assign addr_aligned = {line_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
  assign cnt_d        = cnt_q + CNT_W'(1);
  assign last_beat    = (cnt_q == CNT_W'(BEATS - 1));

  // Read buffer with the current beat slotted in. The result is only
  // captured when a beat is accepted in RD, so that on the final beat the
  // complete line can go straight to line_rdata.
  always_comb begin
    rbuf_d = rbuf_q;
    rbuf_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
  end

  // Burst sequencer: every output except mem_wdata comes from a flop here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      line_resp_q  <= 1'b0;
      line_rdata_q <= '0;
      rbuf_q       <= '0;
      wbuf_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          line_resp_q <= 1'b0;
          cnt_q       <= '0;
          // Reads win when L2 raises both requests together.
          if (line_read) begin
            state_q    <= RD;
            mem_addr_q <= addr_aligned;
            mem_read_q <= 1'b1;
          end else if (line_write) begin
            state_q     <= WR;
            mem_addr_q  <= addr_aligned;
            wbuf_q      <= line_wdata;
            mem_write_q <= 1'b1;
          end
        end
        RD: begin
          if (mem_resp) begin
            rbuf_q <= rbuf_d;
            cnt_q  <= cnt_d;
            if (last_beat) begin
              mem_read_q   <= 1'b0;
              line_rdata_q <= rbuf_d;
              line_resp_q  <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        WR: begin
          if (mem_resp) begin
            cnt_q <= cnt_d;
            if (last_beat) begin
              mem_write_q <= 1'b0;
              line_resp_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          // L2 is still dropping its request here, so nothing is sampled.
          line_resp_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign line_rdata = line_rdata_q;
  assign line_resp  = line_resp_q;
  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = wbuf_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH];

endmodule
